// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: select codes and the
// per-stage destination metadata carried down the pipeline.
package fwd_pkg;
  localparam int SLOT_AW = 5;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               regwrite;
    logic               memread;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

  // x0 is hardwired zero, so a write to it is never a forwardable result
  function automatic logic produces(stage_info_t p, logic [SLOT_AW-1:0] r);
    return p.valid && p.regwrite && (p.rd != '0) && (p.rd == r);
  endfunction
endpackage

// File: rtl/fwd_match.sv
// One operand's view: priority-encodes the EX/MEM producers into a mux select
// and flags a pending load in EX that this operand depends on.
module fwd_match
  import fwd_pkg::*;
(
  input  stage_info_t        ex_i,
  input  stage_info_t        mem_i,
  input  logic [SLOT_AW-1:0] rs_i,
  input  logic               use_i,
  input  logic               bubble_i,
  output fwd_sel_t           sel_o,
  output logic               load_hit_o
);
  always_comb begin
    sel_o = FWD_REG;
    if (!bubble_i && use_i) begin
      // The instruction now in EX is the newest producer, so it wins
      if (produces(ex_i, rs_i))       sel_o = FWD_MEM;
      else if (produces(mem_i, rs_i)) sel_o = FWD_WB;
    end
  end

  assign load_hit_o = use_i && ex_i.valid && ex_i.memread &&
                      (ex_i.rd != '0) && (ex_i.rd == rs_i);
endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM destination slots
// and registers the operand selects for the instruction entering EX.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);
  // The WB slot feeds nothing here: distance-3 dependencies are resolved by
  // the register file's write-before-read, so only EX and MEM are kept.
  stage_info_t      ex_q, ex_d, mem_q;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_hit_a, load_hit_b, bubble;

  fwd_match u_match_a (
    .ex_i(ex_q), .mem_i(mem_q), .rs_i(id_rs1), .use_i(id_use_rs1),
    .bubble_i(bubble), .sel_o(fwd_a_d), .load_hit_o(load_hit_a)
  );

  fwd_match u_match_b (
    .ex_i(ex_q), .mem_i(mem_q), .rs_i(id_rs2), .use_i(id_use_rs2),
    .bubble_i(bubble), .sel_o(fwd_b_d), .load_hit_o(load_hit_b)
  );

  // Priority: hold freezes everything, flush kills the hazard outright
  assign stall  = !hold && !flush && id_valid && (load_hit_a || load_hit_b);
  assign bubble = flush || stall || !id_valid;
  assign ex_d   = bubble ? BUBBLE
                         : '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_cnt_q;
endmodule
